req_priority_arbiter: RTL and testbench



---
 rtl/req_priority_arbiter_pkg.sv | 26 ++
 rtl/req_priority_arbiter_rr_priority_pick.sv | 52 +++++
 rtl/req_priority_arbiter.sv | 122 ++++++++++++
 tb/tb_req_priority_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/req_priority_arbiter_pkg.sv
// Shared definitions for the request priority arbiter.
//   arb_state_t      : arbiter FSM states (IDLE, BUSY)
//   DEFAULT_N        : default number of requesters
//   DEFAULT_MAX_HOLD : default maximum grant length in cycles (0 = no limit)
//   clog2()          : ceiling log2, used for the ID and hold-counter widths
package req_priority_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int DEFAULT_N        = 8;
    localparam int DEFAULT_MAX_HOLD = 16;

    // Smallest r with 2**r >= value; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/req_priority_arbiter_rr_priority_pick.sv
// Combinational priority picker.
//   req       in  N    request vector
//   last      in  IDW  previous winner (start pointer for rotated search)
//   rr_mode   in  1    1 = search LAST-1, LAST-2, ... LAST (mod N); 0 = highest index wins
//   win_valid out 1    at least one request is set
//   win_id    out IDW  index of the winning request (0 when win_valid=0)
module rr_priority_pick #(
    parameter int N   = 8,
    parameter int IDW = 3
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] last,
    input  logic           rr_mode,
    output logic           win_valid,
    output logic [IDW-1:0] win_id
);

    localparam logic [IDW:0] SUM_N = (IDW+1)'(N);

    // Fixed priority is the rotated search started from 0, so one encoder
    // serves both modes.
    logic [IDW-1:0] start;
    assign start = rr_mode ? last : '0;

    // cand_idx[gi] is the index visited at search step gi+1: (start - gi - 1) mod N.
    // One extra bit keeps start + N - 1 - gi from overflowing before the wrap.
    logic [IDW:0]   cand_sum [N];
    logic [IDW-1:0] cand_idx [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_cand
            assign cand_sum[gi] = {1'b0, start} + (IDW+1)'(N - 1 - gi);
            assign cand_idx[gi] = (cand_sum[gi] >= SUM_N) ? IDW'(cand_sum[gi] - SUM_N)
                                                          : IDW'(cand_sum[gi]);
        end
    endgenerate

    // Walk from the last search step to the first so the earliest step that
    // finds a set request is the one left standing.
    always_comb begin
        win_valid = 1'b0;
        win_id    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[cand_idx[i]]) begin
                win_valid = 1'b1;
                win_id    = cand_idx[i];
            end
        end
    end

endmodule

// File: rtl/req_priority_arbiter.sv
// Sequential arbiter sharing one resource among N requesters.
//   clk       in  1    system clock, rising edge
//   rst_n     in  1    asynchronous active-low reset
//   req       in  N    per-requester request level
//   done      in  1    release strobe from the current owner (ignored when idle)
//   gnt       out N    registered one-hot grant
//   gnt_id    out IDW  binary index of the owner, 0 when no grant
//   gnt_valid out 1    high while a grant is held
//   timeout   out 1    one-cycle pulse when a grant is revoked by MAX_HOLD expiry
// A grant is held until the owner pulses done, drops its request, or has held
// it for MAX_HOLD cycles. Every release is followed by one idle cycle.
module req_priority_arbiter
    import req_priority_arbiter_pkg::*;
#(
    parameter int N        = DEFAULT_N,
    parameter int IDW      = clog2(N),
    parameter bit RR_MODE  = 1'b1,
    parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    input  logic           done,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           gnt_valid,
    output logic           timeout
);

    localparam int CNT_W = (clog2(MAX_HOLD + 1) > 0) ? clog2(MAX_HOLD + 1) : 1;
    localparam bit HOLD_LIMIT = (MAX_HOLD != 0);
    // Counter value seen in the last allowed grant cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = HOLD_LIMIT ? CNT_W'(MAX_HOLD - 1) : {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};
    localparam logic [N-1:0]     GNT_ONE  = N'(1);

    arb_state_t     state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [IDW-1:0] last_reg, last_next;
    logic [N-1:0]   gnt_reg, gnt_next;
    logic [IDW-1:0] gnt_id_reg, gnt_id_next;
    logic           timeout_reg, timeout_next;

    logic           win_valid;
    logic [IDW-1:0] win_id;

    rr_priority_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req       (req),
        .last      (last_reg),
        .rr_mode   (RR_MODE),
        .win_valid (win_valid),
        .win_id    (win_id)
    );

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        last_next    = last_reg;
        gnt_next     = gnt_reg;
        gnt_id_next  = gnt_id_reg;
        timeout_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (win_valid) begin
                    state_next  = BUSY;
                    cnt_next    = '0;
                    last_next   = win_id;
                    gnt_next    = GNT_ONE << win_id;
                    gnt_id_next = win_id;
                end
            end
            BUSY: begin
                // Release beats timeout, so a done in the last allowed cycle
                // never raises the timeout pulse.
                if (done || !req[gnt_id_reg]) begin
                    state_next  = IDLE;
                    gnt_next    = '0;
                    gnt_id_next = '0;
                end else if (HOLD_LIMIT && (cnt_reg == CNT_LAST)) begin
                    state_next   = IDLE;
                    gnt_next     = '0;
                    gnt_id_next  = '0;
                    timeout_next = 1'b1;
                end else if (cnt_reg != CNT_SAT) begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next  = IDLE;
                gnt_next    = '0;
                gnt_id_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            last_reg    <= '0;
            gnt_reg     <= '0;
            gnt_id_reg  <= '0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            last_reg    <= last_next;
            gnt_reg     <= gnt_next;
            gnt_id_reg  <= gnt_id_next;
            timeout_reg <= timeout_next;
        end
    end

    assign gnt       = gnt_reg;
    assign gnt_id    = gnt_id_reg;
    assign gnt_valid = (state_reg == BUSY);
    assign timeout   = timeout_reg;

endmodule

// File: tb/tb_req_priority_arbiter.sv
// Bench for req_priority_arbiter: two instances share stimulus.
//   dut_a : round-robin, MAX_HOLD=4
//   dut_b : fixed priority, MAX_HOLD=16
// Both are compared every cycle against a behavioural model; directed
// table vectors and hand sequences add explicit expected values.
module tb_req_priority_arbiter;

    localparam int NREQ = 8;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       done;

    logic [7:0] ga, gb;
    logic [2:0] ida, idb;
    logic       va, vb, toa, tob;

    int checks   = 0;
    int failures = 0;

    // Model state per instance: owner (-1 = none), cycles the grant has been
    // visible, previous winner, and the pending timeout pulse.
    int own_m  [2];
    int held_m [2];
    int last_m [2];
    int to_m   [2];
    int rr_m   [2] = '{1, 0};
    int mh_m   [2] = '{4, 16};

    typedef struct {
        logic [7:0] req;
        logic       done;
        logic       exp_valid;
        logic [2:0] exp_id;
        logic       exp_to;
    } vec_t;

    vec_t tbl[$];

    req_priority_arbiter #(.N(8), .IDW(3), .RR_MODE(1'b1), .MAX_HOLD(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .gnt(ga), .gnt_id(ida), .gnt_valid(va), .timeout(toa)
    );

    req_priority_arbiter #(.N(8), .IDW(3), .RR_MODE(1'b0), .MAX_HOLD(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .gnt(gb), .gnt_id(idb), .gnt_valid(vb), .timeout(tob)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            own_m[m]  = -1;
            held_m[m] = 0;
            last_m[m] = 0;
            to_m[m]   = 0;
        end
    endtask

    // One clock edge of the arbiter rules, given the inputs sampled at it.
    task automatic model_step(input int m, input logic [7:0] r, input logic d);
        int w;
        int idx;
        to_m[m] = 0;
        if (own_m[m] < 0) begin
            if (r != 8'h00) begin
                w = -1;
                for (int k = 1; k <= NREQ; k++) begin
                    idx = (rr_m[m] != 0) ? (last_m[m] - k + NREQ) % NREQ : NREQ - k;
                    if (w < 0 && r[idx]) w = idx;
                end
                own_m[m]  = w;
                held_m[m] = 1;
                last_m[m] = w;
            end
        end else if (d || !r[own_m[m]]) begin
            own_m[m] = -1;
        end else if (mh_m[m] != 0 && held_m[m] == mh_m[m]) begin
            own_m[m] = -1;
            to_m[m]  = 1;
        end else begin
            held_m[m]++;
        end
    endtask

    task automatic chk_dut(input int m, input logic [7:0] g, input logic [2:0] id,
                           input logic v, input logic t);
        string pfx;
        int eg, eid;
        pfx = (m == 0) ? "a_" : "b_";
        eg  = (own_m[m] >= 0) ? (1 << own_m[m]) : 0;
        eid = (own_m[m] >= 0) ? own_m[m] : 0;
        chk({pfx, "gnt"}, int'(g), eg);
        chk({pfx, "gnt_id"}, int'(id), eid);
        chk({pfx, "gnt_valid"}, int'(v), (own_m[m] >= 0) ? 1 : 0);
        chk({pfx, "timeout"}, int'(t), to_m[m]);
    endtask

    // Apply inputs for one cycle, sample 1 time unit after the edge.
    task automatic step(input logic [7:0] r, input logic d);
        req  = r;
        done = d;
        @(posedge clk);
        #1;
        model_step(0, r, d);
        model_step(1, r, d);
        $display("step req=%02h done=%0d | a gnt=%02h id=%0d v=%0d to=%0d | b gnt=%02h id=%0d v=%0d to=%0d",
                 r, d, ga, ida, va, toa, gb, idb, vb, tob);
        chk_dut(0, ga, ida, va, toa);
        chk_dut(1, gb, idb, vb, tob);
    endtask

    task automatic do_reset();
        req   = 8'h00;
        done  = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic add_vec(input logic [7:0] r, input logic d, input logic v,
                           input logic [2:0] id, input logic t);
        vec_t e;
        e.req = r; e.done = d; e.exp_valid = v; e.exp_id = id; e.exp_to = t;
        tbl.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] r;
        logic       d;

        // RR sweep with done in the first busy cycle: 7,6,...,0,7.
        for (int g = 0; g < 9; g++) begin
            add_vec(8'hFF, 1'b0, 1'b1, 3'((15 - g) % 8), 1'b0);
            add_vec(8'hFF, 1'b1, 1'b0, 3'd0, 1'b0);
        end
        // Timeout after 4 visible cycles, pulse, then regrant of 4.
        for (int i = 0; i < 4; i++) add_vec(8'h10, 1'b0, 1'b1, 3'd4, 1'b0);
        add_vec(8'h10, 1'b0, 1'b0, 3'd0, 1'b1);
        add_vec(8'h10, 1'b0, 1'b1, 3'd4, 1'b0);
        // Done in the 4th grant cycle collides with timeout: release wins.
        for (int i = 0; i < 3; i++) add_vec(8'h10, 1'b0, 1'b1, 3'd4, 1'b0);
        add_vec(8'h10, 1'b1, 1'b0, 3'd0, 1'b0);
        add_vec(8'h00, 1'b0, 1'b0, 3'd0, 1'b0);

        // Reset state.
        do_reset();
        chk("reset_gnt_a", int'(ga), 0);
        chk("reset_valid_a", int'(va), 0);
        chk("reset_timeout_a", int'(toa), 0);
        chk("reset_gnt_b", int'(gb), 0);

        // Reset mid-grant drops outputs without waiting for an edge.
        step(8'h10, 1'b0);
        chk("midrst_granted", int'(va), 1);
        step(8'h10, 1'b0);
        rst_n = 1'b0;
        #2;
        chk("midrst_gnt_a", int'(ga), 0);
        chk("midrst_valid_a", int'(va), 0);
        chk("midrst_timeout_a", int'(toa), 0);
        chk("midrst_gnt_b", int'(gb), 0);
        chk("midrst_valid_b", int'(vb), 0);
        model_reset();
        #1 rst_n = 1'b1;
        step(8'h81, 1'b0);
        chk("postrst_gnt_a", int'(ga), 'h80);
        chk("postrst_id_a", int'(ida), 7);
        chk("postrst_gnt_b", int'(gb), 'h80);

        // Table vectors on the round-robin instance.
        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].req, tbl[i].done);
            chk("tbl_valid", int'(va), int'(tbl[i].exp_valid));
            chk("tbl_id", int'(ida), int'(tbl[i].exp_id));
            chk("tbl_timeout", int'(toa), int'(tbl[i].exp_to));
        end

        // Fixed priority: 2C -> 5, held, done, idle cycle, 5 again.
        do_reset();
        step(8'h2C, 1'b0);
        chk("fixed_gnt", int'(gb), 'h20);
        chk("fixed_id", int'(idb), 5);
        for (int i = 0; i < 3; i++) begin
            step(8'h2C, 1'b0);
            chk("fixed_hold", int'(gb), 'h20);
        end
        step(8'h2C, 1'b1);
        chk("fixed_release_gnt", int'(gb), 0);
        chk("fixed_release_valid", int'(vb), 0);
        step(8'h2C, 1'b0);
        chk("fixed_regrant", int'(gb), 'h20);

        // Abandon in RR mode: owner 3 drops its request, requester 0 follows.
        do_reset();
        step(8'h09, 1'b0);
        chk("abandon_owner", int'(ida), 3);
        step(8'h09, 1'b0);
        step(8'h01, 1'b0);
        chk("abandon_clear", int'(ga), 0);
        chk("abandon_no_to", int'(toa), 0);
        step(8'h01, 1'b0);
        chk("abandon_next_gnt", int'(ga), 'h01);
        chk("abandon_next_id", int'(ida), 0);

        // Random traffic against the model; requests mostly stay stable so
        // timeouts and long holds occur.
        do_reset();
        r = 8'h00;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                r = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            end
            d = ($urandom_range(0, 7) == 0);
            step(r, d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
